alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16, operand/result width; SHALL come from the shared package.
REQ-002 Parameter INST_ADDR_LENGTH, default 2, ALU register-file address width; SHALL come from the shared package.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rstN  in  1  reset, asynchronous, active-low.
REQ-005 cmdValid  in  1 / cmdReady  out  1  command handshake.
REQ-006 cmdOp  in  OPERAND_WIDTH  opcode; cmdA, cmdB  in  OPERAND_WIDTH  operands.
REQ-007 aluWriteEn  out  1 / aluWriteAddr  out  INST_ADDR_LENGTH / aluInst  out  OPERAND_WIDTH  ALU register-file write port.
REQ-008 aluResult  in  OPERAND_WIDTH; aluError, aluZero, aluCarry, aluOverflow  in  1  ALU outputs.
REQ-009 rspValid  out  1 / rspReady  in  1  response handshake.
REQ-010 rspResult, rspHi  out  OPERAND_WIDTH; rspFlags  out  4  {error,zero,carry,overflow}; busy  out  1  high when not IDLE.

Function
REQ-011 Command accepted on the edge where cmdValid && cmdReady; cmdReady SHALL be high only in IDLE; cmdOp/cmdA/cmdB SHALL be registered at acceptance.
REQ-012 States: IDLE, WR_A, WR_B, WR_OP, SETTLE, MULT_WAIT, WR_HI, CAP_HI, RESP.
REQ-013 WR_A: aluWriteEn=1, addr=REG_A (1), aluInst=A. WR_B: addr=REG_B (2), aluInst=B. WR_OP: addr=REG_OP (0), aluInst=op. The opcode SHALL always be written last.
REQ-014 aluWriteEn SHALL be 0 in all other states; aluWriteAddr/aluInst SHALL be 0 when aluWriteEn=0.
REQ-015 SETTLE (1 cycle): for non-MULT ops, capture aluResult and flags at end of cycle, then go to RESP.
REQ-016 For OP_MULT: SETTLE -> MULT_WAIT; capture aluResult as rspResult (low word) and flags at end of MULT_WAIT.
REQ-017 For OP_MULT: WR_HI then writes OP_MFHI to REG_OP; CAP_HI captures aluResult into rspHi; then RESP.
REQ-018 rspHi SHALL be 0 for all non-MULT ops.
REQ-019 Latency: rspValid SHALL rise 5 cycles after acceptance for non-MULT ops and 8 cycles after acceptance for OP_MULT.
REQ-020 RESP: rspValid=1, with rspResult/rspHi/rspFlags held stable until rspValid && rspReady, then go to IDLE; cmdReady SHALL not rise in the same cycle.
REQ-021 Invalid opcodes SHALL be forwarded unchanged; the ALU's error flag is reported in rspFlags[3] with no special handling.
REQ-022 OP_DIVIDE with B=0 SHALL complete normally and report the ALU's error flag and result.
REQ-023 The command inputs SHALL be ignored outside IDLE.

Reset
REQ-024 rstN low SHALL force IDLE at any state; cmdReady=1 after release; rspValid=0, aluWriteEn=0, aluWriteAddr=0, aluInst=0, rspResult=0, rspHi=0, rspFlags=0, busy=0.
REQ-025 A reset mid-sequence SHALL discard the command and produce no response.

Structure
REQ-026 The shared package SHALL hold the opcode constants (incl. OP_MULT, OP_MFHI), OPERAND_WIDTH, INST_ADDR_LENGTH, REG_OP/REG_A/REG_B addresses and the state enum typedef.
REQ-027 The block SHALL be a single module with no sub-modules; it connects point-to-point to the ALU top's write port and outputs.

Verification
REQ-028 OP_ADD A=0x0005 B=0x0003 -> write trace addr 1,2,0 on cycles 1-3; rspValid at cycle 5; rspResult=0x0008, rspHi=0, rspFlags=0000.
REQ-029 OP_MULT A=0x1234 B=0x0100 -> rspValid at cycle 8; rspResult=0x3400, rspHi=0x0012; an OP_MFHI write is observed in WR_HI.
REQ-030 OP_DIVIDE A=0x0010 B=0x0000 -> rspResult=0x0000, rspFlags[3]=1.
REQ-031 rspReady held low 3 cycles in RESP -> outputs stable and cmdReady=0 throughout; IDLE entered the cycle after rspReady=1.
REQ-032 rstN pulsed low during WR_B -> all outputs at reset values, no rspValid; the next command (OP_SUB 0x0001-0x0002) yields 0xFFFF with carry=1.
REQ-033 cmdValid held high back-to-back with rspReady=1 -> one command per RESP->IDLE cycle; no writes are issued outside WR_* states.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: operand/address widths,
// opcodes, ALU register-file addresses and the sequencer state encoding.
package alu_cmd_sequencer_pkg;

    localparam int OPERAND_WIDTH    = 16;
    localparam int INST_ADDR_LENGTH = 2;

    localparam logic [OPERAND_WIDTH-1:0] OP_ADD    = OPERAND_WIDTH'(0);
    localparam logic [OPERAND_WIDTH-1:0] OP_SUB    = OPERAND_WIDTH'(1);
    localparam logic [OPERAND_WIDTH-1:0] OP_AND    = OPERAND_WIDTH'(2);
    localparam logic [OPERAND_WIDTH-1:0] OP_OR     = OPERAND_WIDTH'(3);
    localparam logic [OPERAND_WIDTH-1:0] OP_XOR    = OPERAND_WIDTH'(4);
    localparam logic [OPERAND_WIDTH-1:0] OP_MULT   = OPERAND_WIDTH'(5);
    localparam logic [OPERAND_WIDTH-1:0] OP_DIVIDE = OPERAND_WIDTH'(6);
    localparam logic [OPERAND_WIDTH-1:0] OP_MFHI   = OPERAND_WIDTH'(7);

    localparam logic [INST_ADDR_LENGTH-1:0] REG_OP = INST_ADDR_LENGTH'(0);
    localparam logic [INST_ADDR_LENGTH-1:0] REG_A  = INST_ADDR_LENGTH'(1);
    localparam logic [INST_ADDR_LENGTH-1:0] REG_B  = INST_ADDR_LENGTH'(2);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WR_A      = 4'd1;
    localparam logic [3:0] ST_WR_B      = 4'd2;
    localparam logic [3:0] ST_WR_OP     = 4'd3;
    localparam logic [3:0] ST_SETTLE    = 4'd4;
    localparam logic [3:0] ST_MULT_WAIT = 4'd5;
    localparam logic [3:0] ST_WR_HI     = 4'd6;
    localparam logic [3:0] ST_CAP_HI    = 4'd7;
    localparam logic [3:0] ST_RESP      = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        WR_A      = ST_WR_A,
        WR_B      = ST_WR_B,
        WR_OP     = ST_WR_OP,
        SETTLE    = ST_SETTLE,
        MULT_WAIT = ST_MULT_WAIT,
        WR_HI     = ST_WR_HI,
        CAP_HI    = ST_CAP_HI,
        RESP      = ST_RESP
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Turns one {op, A, B} command into ALU register-file writes, waits for the
// ALU to settle (plus the MFHI read-back for multiplies) and returns the result.
module alu_cmd_sequencer #(
    parameter int OPERAND_WIDTH    = alu_cmd_sequencer_pkg::OPERAND_WIDTH,
    parameter int INST_ADDR_LENGTH = alu_cmd_sequencer_pkg::INST_ADDR_LENGTH
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        cmdValid,
    output logic                        cmdReady,
    input  logic [OPERAND_WIDTH-1:0]    cmdOp,
    input  logic [OPERAND_WIDTH-1:0]    cmdA,
    input  logic [OPERAND_WIDTH-1:0]    cmdB,
    output logic                        aluWriteEn,
    output logic [INST_ADDR_LENGTH-1:0] aluWriteAddr,
    output logic [OPERAND_WIDTH-1:0]    aluInst,
    input  logic [OPERAND_WIDTH-1:0]    aluResult,
    input  logic                        aluError,
    input  logic                        aluZero,
    input  logic                        aluCarry,
    input  logic                        aluOverflow,
    output logic                        rspValid,
    input  logic                        rspReady,
    output logic [OPERAND_WIDTH-1:0]    rspResult,
    output logic [OPERAND_WIDTH-1:0]    rspHi,
    output logic [3:0]                  rspFlags,
    output logic                        busy
);
    import alu_cmd_sequencer_pkg::*;

    state_e                     state_reg;
    state_e                     state_next;
    logic [OPERAND_WIDTH-1:0]   op_reg;
    logic [OPERAND_WIDTH-1:0]   a_reg;
    logic [OPERAND_WIDTH-1:0]   b_reg;
    logic [OPERAND_WIDTH-1:0]   result_reg;
    logic [OPERAND_WIDTH-1:0]   hi_reg;
    logic [3:0]                 flags_reg;
    logic                       is_mult;

    assign is_mult = (op_reg == OPERAND_WIDTH'(OP_MULT));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (cmdValid) state_next = WR_A;
            WR_A:      state_next = WR_B;
            WR_B:      state_next = WR_OP;
            WR_OP:     state_next = SETTLE;
            SETTLE:    state_next = is_mult ? MULT_WAIT : RESP;
            MULT_WAIT: state_next = WR_HI;
            WR_HI:     state_next = CAP_HI;
            CAP_HI:    state_next = RESP;
            RESP:      if (rspReady) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            hi_reg     <= '0;
            flags_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (cmdValid) begin
                        op_reg     <= cmdOp;
                        a_reg      <= cmdA;
                        b_reg      <= cmdB;
                        result_reg <= '0;
                        hi_reg     <= '0;
                        flags_reg  <= '0;
                    end
                end
                SETTLE: begin
                    if (!is_mult) begin
                        result_reg <= aluResult;
                        flags_reg  <= {aluError, aluZero, aluCarry, aluOverflow};
                    end
                end
                // The multiplier needs an extra cycle before the low word is valid
                MULT_WAIT: begin
                    result_reg <= aluResult;
                    flags_reg  <= {aluError, aluZero, aluCarry, aluOverflow};
                end
                CAP_HI:  hi_reg <= aluResult;
                default: ;
            endcase
        end
    end

    // Opcode goes last so the ALU only evaluates once both operands are in place
    always_comb begin
        aluWriteEn   = 1'b0;
        aluWriteAddr = '0;
        aluInst      = '0;
        case (state_reg)
            WR_A: begin
                aluWriteEn   = 1'b1;
                aluWriteAddr = INST_ADDR_LENGTH'(REG_A);
                aluInst      = a_reg;
            end
            WR_B: begin
                aluWriteEn   = 1'b1;
                aluWriteAddr = INST_ADDR_LENGTH'(REG_B);
                aluInst      = b_reg;
            end
            WR_OP: begin
                aluWriteEn   = 1'b1;
                aluWriteAddr = INST_ADDR_LENGTH'(REG_OP);
                aluInst      = op_reg;
            end
            WR_HI: begin
                aluWriteEn   = 1'b1;
                aluWriteAddr = INST_ADDR_LENGTH'(REG_OP);
                aluInst      = OPERAND_WIDTH'(OP_MFHI);
            end
            default: ;
        endcase
    end

    assign cmdReady  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign rspValid  = (state_reg == RESP);
    assign rspResult = result_reg;
    assign rspHi     = hi_reg;
    assign rspFlags  = flags_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: an ALU register-file stub answers the write port, the
// driver queues expected writes/responses and a negedge monitor checks them.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int W = OPERAND_WIDTH;
    typedef logic [W-1:0] word_t;
    typedef struct packed { word_t lo; word_t hi; logic [3:0] flags; } alu_out_t;
    typedef struct { int due; logic [INST_ADDR_LENGTH-1:0] addr; word_t data; } wr_exp_t;
    typedef struct { int due; word_t op; word_t res; word_t hi; logic [3:0] flags; } rsp_exp_t;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic                        cmdValid;
    logic                        cmdReady;
    word_t                       cmdOp, cmdA, cmdB;
    logic                        aluWriteEn;
    logic [INST_ADDR_LENGTH-1:0] aluWriteAddr;
    word_t                       aluInst;
    word_t                       aluResult;
    logic                        aluError, aluZero, aluCarry, aluOverflow;
    logic                        rspValid;
    logic                        rspReady = 1'b0;
    word_t                       rspResult, rspHi;
    logic [3:0]                  rspFlags;
    logic                        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int hold_cnt = 0;
    wr_exp_t  wq[$];
    rsp_exp_t rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer dut (
        .clk(clk), .rstN(rstN),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
        .aluWriteEn(aluWriteEn), .aluWriteAddr(aluWriteAddr), .aluInst(aluInst),
        .aluResult(aluResult), .aluError(aluError), .aluZero(aluZero),
        .aluCarry(aluCarry), .aluOverflow(aluOverflow),
        .rspValid(rspValid), .rspReady(rspReady),
        .rspResult(rspResult), .rspHi(rspHi), .rspFlags(rspFlags),
        .busy(busy)
    );

    // Arithmetic meaning of each opcode, flags = {error, zero, carry, overflow}
    function automatic alu_out_t alu_model(input word_t op, input word_t a, input word_t b);
        alu_out_t r;
        int       u, sg;
        longint   pr;
        logic     err, c, v;
        r = '0; err = 1'b0; c = 1'b0; v = 1'b0;
        pr = longint'(a) * longint'(b);
        case (op)
            OP_ADD: begin
                u = int'(a) + int'(b);
                sg = int'($signed(a)) + int'($signed(b));
                r.lo = word_t'(u);
                c = (u > (1 << W) - 1);
                v = (sg > (1 << (W-1)) - 1) || (sg < -(1 << (W-1)));
            end
            OP_SUB: begin
                u = int'(a) - int'(b);
                sg = int'($signed(a)) - int'($signed(b));
                r.lo = word_t'(u);
                c = (u < 0);
                v = (sg > (1 << (W-1)) - 1) || (sg < -(1 << (W-1)));
            end
            OP_AND: r.lo = a & b;
            OP_OR:  r.lo = a | b;
            OP_XOR: r.lo = a ^ b;
            OP_MULT: begin
                r.lo = word_t'(pr);
                r.hi = word_t'(pr >> W);
                v = (r.hi != '0);
            end
            OP_DIVIDE: if (b == '0) err = 1'b1; else r.lo = a / b;
            OP_MFHI: r.lo = word_t'(pr >> W);
            default: err = 1'b1;
        endcase
        r.flags = {err, (r.lo == '0), c, v};
        return r;
    endfunction

    // ALU stub: register file plus a multiplier whose low word is only valid one cycle late
    word_t    alu_rf [0:3];
    int       op_age;
    alu_out_t alu_now;
    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) alu_rf[i] <= '0;
            op_age <= 10;
        end else begin
            if (aluWriteEn) alu_rf[aluWriteAddr] <= aluInst;
            if (aluWriteEn && aluWriteAddr == REG_OP) op_age <= 0;
            else if (op_age < 10) op_age <= op_age + 1;
        end
    end
    always_comb begin
        alu_now = alu_model(alu_rf[REG_OP], alu_rf[REG_A], alu_rf[REG_B]);
        if (alu_rf[REG_OP] == OP_MULT && op_age == 0) alu_now = {16'hBAD0, 16'hBAD1, 4'b1111};
    end
    assign aluResult = alu_now.lo;
    assign {aluError, aluZero, aluCarry, aluOverflow} = alu_now.flags;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int due, input logic [INST_ADDR_LENGTH-1:0] addr, input word_t data);
        wr_exp_t e;
        e.due = due; e.addr = addr; e.data = data;
        wq.push_back(e);
    endtask

    // Called in the cycle before the accepting edge; cyc+k is k cycles after acceptance
    task automatic push_expect(input word_t op, input word_t a, input word_t b);
        alu_out_t m;
        rsp_exp_t r;
        logic     mult;
        m = alu_model(op, a, b);
        mult = (op == OP_MULT);
        push_wr(cyc + 1, REG_A, a);
        push_wr(cyc + 2, REG_B, b);
        push_wr(cyc + 3, REG_OP, op);
        if (mult) push_wr(cyc + 6, REG_OP, OP_MFHI);
        r.due = cyc + (mult ? 8 : 5);
        r.op = op;
        r.res = m.lo;
        r.hi = mult ? m.hi : '0;
        r.flags = m.flags;
        rq.push_back(r);
    endtask

    task automatic send(input word_t op, input word_t a, input word_t b);
        int t = 0;
        cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b;
        while (!cmdReady && t < 200) begin @(posedge clk); #1; t++; end
        if (!cmdReady) chk("cmd_accept_timeout", 1'b0, 64'(cmdReady), 64'd1);
        else push_expect(op, a, b);
        @(posedge clk); #1;
        cmdOp = word_t'($urandom); cmdA = word_t'($urandom); cmdB = word_t'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((rq.size() != 0 || !cmdReady) && t < 300) begin @(posedge clk); #1; t++; end
        if (t >= 300) chk("drain_timeout", 1'b0, 64'(rq.size()), 64'd0);
    endtask

    function automatic word_t rand_op();
        int k = int'($urandom_range(0, 10));
        case (k)
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_XOR;
            5, 6: return OP_MULT;
            7, 8: return OP_DIVIDE;
            9: return OP_MFHI;
            default: return word_t'($urandom_range(8, (1 << W) - 1));
        endcase
    endfunction

    function automatic word_t rand_b();
        return ($urandom_range(0, 3) == 0) ? '0 : word_t'($urandom);
    endfunction

    always begin
        @(posedge clk); #1;
        if (!rspValid) hold_cnt = 0;
        case (rdy_mode)
            0: rspReady = 1'b1;
            1: rspReady = 1'($urandom_range(0, 1));
            default: begin
                if (rspValid && hold_cnt < 3) begin rspReady = 1'b0; hold_cnt++; end
                else rspReady = 1'b1;
            end
        endcase
    end

    logic     in_resp = 1'b0;
    logic     ack_pending = 1'b0;
    word_t    held_res, held_hi;
    logic [3:0] held_flags;
    wr_exp_t  we;
    rsp_exp_t re;

    always @(negedge clk) begin
        if (!rstN) begin
            chk("reset_outputs",
                {rspValid, aluWriteEn, aluWriteAddr, aluInst, rspResult, rspHi, rspFlags, busy} === '0,
                64'({rspValid, aluWriteEn, aluWriteAddr, aluInst, rspResult, rspHi, rspFlags, busy}), 64'd0);
            wq.delete(); rq.delete();
            in_resp = 1'b0; ack_pending = 1'b0;
        end else begin
            while (wq.size() > 0 && wq[0].due < cyc) begin
                chk("missing_write", 1'b0, 64'd0, 64'({wq[0].addr, wq[0].data}));
                wq.delete(0);
            end
            if (!in_resp && rq.size() > 0 && rq[0].due < cyc) begin
                chk("missing_rsp", 1'b0, 64'd0, 64'(rq[0].res));
                rq.delete(0);
            end
            if (aluWriteEn) begin
                if (wq.size() == 0) chk("unexpected_write", 1'b0, 64'({aluWriteAddr, aluInst}), 64'd0);
                else begin
                    we = wq.pop_front();
                    chk("write_port", aluWriteAddr === we.addr && aluInst === we.data && cyc == we.due,
                        64'({16'(cyc), aluWriteAddr, aluInst}), 64'({16'(we.due), we.addr, we.data}));
                end
            end else begin
                chk("write_idle_zero", aluWriteAddr === '0 && aluInst === '0,
                    64'({aluWriteAddr, aluInst}), 64'd0);
            end
            if (rspValid) begin
                if (!in_resp) begin
                    if (rq.size() == 0) chk("unexpected_rsp", 1'b0, 64'(rspResult), 64'd0);
                    else begin
                        re = rq.pop_front();
                        chk("rsp_latency", cyc == re.due, 64'(cyc), 64'(re.due));
                        chk("rsp_result", rspResult === re.res, 64'(rspResult), 64'(re.res));
                        chk("rsp_hi", rspHi === re.hi, 64'(rspHi), 64'(re.hi));
                        chk("rsp_flags", rspFlags === re.flags, 64'(rspFlags), 64'(re.flags));
                        $display("rsp op=%h result=%h hi=%h flags=%b cycle=%0d",
                                 re.op, rspResult, rspHi, rspFlags, cyc);
                    end
                    in_resp = 1'b1;
                    held_res = rspResult; held_hi = rspHi; held_flags = rspFlags;
                end else begin
                    chk("rsp_stable", {rspResult, rspHi, rspFlags} === {held_res, held_hi, held_flags},
                        64'({rspResult, rspHi, rspFlags}), 64'({held_res, held_hi, held_flags}));
                end
                chk("cmdready_in_resp", cmdReady === 1'b0 && busy === 1'b1,
                    64'({cmdReady, busy}), 64'(2'b01));
                if (rspReady) begin in_resp = 1'b0; ack_pending = 1'b1; end
            end else begin
                if (ack_pending)
                    chk("idle_after_ack", cmdReady === 1'b1 && busy === 1'b0,
                        64'({cmdReady, busy}), 64'(2'b10));
                ack_pending = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdA = '0; cmdB = '0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk); #1;
        chk("cmdready_after_reset", cmdReady === 1'b1, 64'(cmdReady), 64'd1);

        send(OP_ADD, 16'h0005, 16'h0003); cmdValid = 1'b0; wait_idle();
        send(OP_MULT, 16'h1234, 16'h0100); cmdValid = 1'b0; wait_idle();
        send(OP_DIVIDE, 16'h0010, 16'h0000); cmdValid = 1'b0; wait_idle();

        rdy_mode = 2;
        send(OP_XOR, word_t'($urandom), word_t'($urandom)); cmdValid = 1'b0; wait_idle();
        send(OP_MULT, word_t'($urandom), word_t'($urandom)); cmdValid = 1'b0; wait_idle();
        rdy_mode = 0;

        // Reset lands while the sequencer is writing B
        send(OP_ADD, 16'h1111, 16'h2222); cmdValid = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("no_rsp_after_reset", rspValid === 1'b0, 64'(rspValid), 64'd0);
            @(posedge clk); #1;
        end
        send(OP_SUB, 16'h0001, 16'h0002); cmdValid = 1'b0; wait_idle();

        // Back-to-back with cmdValid never dropping
        for (int i = 0; i < 10; i++) send(rand_op(), word_t'($urandom), rand_b());
        cmdValid = 1'b0; wait_idle();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(rand_op(), word_t'($urandom), rand_b());
            cmdValid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
